// File: rtl/jtframe_mr_ddrslave.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_mr_ddrslave
// Purpose  : Avalon-MM burst responder backed by a 64-bit block RAM; stands in
//            for the MiSTer HPS DDR port, with optional periodic busy insertion.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_mr_ddrslave #(
    parameter int AW         = 10,
    parameter int BUSY_EVERY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ddr_burstcnt,
    input  logic [28:0] ddr_addr,
    input  logic        ddr_rd,
    input  logic        ddr_we,
    input  logic [7:0]  ddr_be,
    input  logic [63:0] ddr_din,
    output logic        ddr_busy,
    output logic [63:0] ddr_dout,
    output logic        ddr_dout_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_t          state, state_nxt;
    logic [AW-1:0]   addr_q, addr_nxt;
    logic [7:0]      remaining, remaining_nxt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            rd_en;
    logic            inj_busy;
    logic            state_busy;
    logic            unused_addr_bits;

    logic [63:0]     mem [0:(1<<AW)-1];

    assign unused_addr_bits = ^ddr_addr[28:AW];

    // Busy covers the whole read, including the cycle the last word is presented.
    assign state_busy = (state == READ) | ddr_dout_ready;
    assign ddr_busy   = state_busy | inj_busy;

    generate
        if (BUSY_EVERY != 0) begin : g_busy_insert
            localparam int CW = (BUSY_EVERY > 1) ? $clog2(BUSY_EVERY) : 1;
            localparam logic [CW-1:0] LAST = CW'(BUSY_EVERY - 1);
            logic [CW-1:0] busy_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    busy_cnt <= '0;
                end else begin
                    busy_cnt <= (busy_cnt == LAST) ? '0 : busy_cnt + CW'(1);
                end
            end

            assign inj_busy = (busy_cnt == LAST);
        end else begin : g_no_busy
            assign inj_busy = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_q;
        remaining_nxt = remaining;
        wr_en         = 1'b0;
        wr_addr       = addr_q;
        rd_en         = 1'b0;
        case (state)
            IDLE: begin
                if (!ddr_busy) begin
                    if (ddr_we) begin
                        wr_en   = 1'b1;
                        wr_addr = ddr_addr[AW-1:0];
                        if (ddr_burstcnt > 8'd1) begin
                            state_nxt     = WRITE;
                            remaining_nxt = ddr_burstcnt - 8'd1;
                            addr_nxt      = ddr_addr[AW-1:0] + ADDR_ONE;
                        end
                    end else if (ddr_rd) begin
                        state_nxt     = READ;
                        addr_nxt      = ddr_addr[AW-1:0];
                        remaining_nxt = (ddr_burstcnt == 8'd0) ? 8'd1 : ddr_burstcnt;
                    end
                end
            end
            WRITE: begin
                if (ddr_we && !ddr_busy) begin
                    wr_en         = 1'b1;
                    addr_nxt      = addr_q + ADDR_ONE;
                    remaining_nxt = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state_nxt = IDLE;
                    end
                end
            end
            READ: begin
                // One BRAM read per cycle; injected busy never stalls the stream.
                rd_en         = 1'b1;
                addr_nxt      = addr_q + ADDR_ONE;
                remaining_nxt = remaining - 8'd1;
                if (remaining == 8'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr_q         <= '0;
            remaining      <= 8'd0;
            ddr_dout_ready <= 1'b0;
            ddr_dout       <= 64'd0;
        end else begin
            state          <= state_nxt;
            addr_q         <= addr_nxt;
            remaining      <= remaining_nxt;
            ddr_dout_ready <= rd_en;
            if (rd_en) begin
                ddr_dout <= mem[addr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (ddr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= ddr_din[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_mr_ddrslave.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_mr_ddrslave
// Purpose  : Directed self-checking bench for the DDR burst responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_mr_ddrslave;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ddr_burstcnt;
    logic [28:0] ddr_addr;
    logic        ddr_rd;
    logic        ddr_we;
    logic [7:0]  ddr_be;
    logic [63:0] ddr_din;
    logic        busy0, ready0, busy3, ready3;
    logic [63:0] dout0, dout3;

    int vectors = 0;
    int errors  = 0;
    int mcnt;

    logic [63:0] rd_words [0:63];
    int          rd_cyc   [0:63];
    logic        rd_busy  [0:63];
    int          rd_n;
    int          rd_wait;

    jtframe_mr_ddrslave #(.AW(10), .BUSY_EVERY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ddr_burstcnt(ddr_burstcnt), .ddr_addr(ddr_addr),
        .ddr_rd(ddr_rd), .ddr_we(ddr_we), .ddr_be(ddr_be), .ddr_din(ddr_din),
        .ddr_busy(busy0), .ddr_dout(dout0), .ddr_dout_ready(ready0)
    );

    jtframe_mr_ddrslave #(.AW(10), .BUSY_EVERY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ddr_burstcnt(ddr_burstcnt), .ddr_addr(ddr_addr),
        .ddr_rd(ddr_rd), .ddr_we(ddr_we), .ddr_be(ddr_be), .ddr_din(ddr_din),
        .ddr_busy(busy3), .ddr_dout(dout3), .ddr_dout_ready(ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference phase of the injected busy: high every third cycle after reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 0;
        else        mcnt <= (mcnt == 2) ? 0 : mcnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic get_busy(input int sel);
        return (sel == 3) ? busy3 : busy0;
    endfunction

    function automatic logic get_ready(input int sel);
        return (sel == 3) ? ready3 : ready0;
    endfunction

    function automatic logic [63:0] get_dout(input int sel);
        return (sel == 3) ? dout3 : dout0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input int sel, input logic [28:0] a, input logic [63:0] d,
                       input logic [7:0] be);
        for (int w = 0; w < 20 && get_busy(sel); w++) tick();
        ddr_addr = a; ddr_din = d; ddr_be = be; ddr_burstcnt = 8'd1; ddr_we = 1'b1;
        tick();
        ddr_we = 1'b0;
    endtask

    // Issue one read when the chosen DUT is free, then log 40 cycles of response.
    task automatic do_read(input int sel, input logic [28:0] a, input logic [7:0] n);
        rd_wait = 0;
        while (get_busy(sel) && rd_wait < 20) begin
            tick();
            rd_wait++;
        end
        ddr_addr = a; ddr_burstcnt = n; ddr_rd = 1'b1;
        tick();
        ddr_rd = 1'b0;
        rd_n = 0;
        for (int t = 1; t <= 40; t++) begin
            rd_busy[t] = get_busy(sel);
            if (get_ready(sel)) begin
                if (rd_n < 64) begin
                    rd_words[rd_n] = get_dout(sel);
                    rd_cyc[rd_n]   = t;
                end
                rd_n++;
            end
            if (t < 40) tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ddr_rd = 1'b0; ddr_we = 1'b0; ddr_be = 8'h00; ddr_din = 64'd0;
        ddr_addr = 29'd0; ddr_burstcnt = 8'd0;
        #1;
        vectors++;
        if (busy0 !== 1'b0 || ready0 !== 1'b0 || dout0 !== 64'd0) begin
            errors++;
            $display("FAIL reset_dut0: busy=%b ready=%b dout=%h expected 0 0 0", busy0, ready0, dout0);
        end
        vectors++;
        if (busy3 !== 1'b0 || ready3 !== 1'b0 || dout3 !== 64'd0) begin
            errors++;
            $display("FAIL reset_dut3: busy=%b ready=%b dout=%h expected 0 0 0", busy3, ready3, dout3);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        wr1(0, 29'h10, 64'h0123456789ABCDEF, 8'hFF);
        do_read(0, 29'h10, 8'd1);
        vectors++;
        if (rd_wait !== 0 || rd_n !== 1) begin
            errors++;
            $display("FAIL single_count: wait=%0d words=%0d expected 0 1", rd_wait, rd_n);
        end
        vectors++;
        if (rd_cyc[0] !== 2 || rd_words[0] !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL single_data: cycle=%0d data=%h expected 2 0123456789abcdef", rd_cyc[0], rd_words[0]);
        end
        vectors++;
        if (rd_busy[1] !== 1'b1 || rd_busy[2] !== 1'b1 || rd_busy[3] !== 1'b0) begin
            errors++;
            $display("FAIL single_busy: T+1..T+3=%b%b%b expected 110", rd_busy[1], rd_busy[2], rd_busy[3]);
        end
        vectors++;
        if (ready0 !== 1'b0 || dout0 !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL dout_hold: ready=%b dout=%h expected 0 0123456789abcdef", ready0, dout0);
        end
    endtask

    task automatic test_byte_enable();
        wr1(0, 29'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        wr1(0, 29'h20, 64'h0, 8'h0F);
        do_read(0, 29'h20, 8'd1);
        vectors++;
        if (rd_n !== 1 || rd_words[0] !== 64'hFFFFFFFF00000000) begin
            errors++;
            $display("FAIL byte_enable: words=%0d data=%h expected 1 ffffffff00000000", rd_n, rd_words[0]);
        end
    endtask

    task automatic test_write_burst();
        logic busy_seen;
        busy_seen = 1'b0;
        ddr_addr = 29'h100; ddr_burstcnt = 8'd4; ddr_be = 8'hFF;
        ddr_din = 64'd1; ddr_we = 1'b1;
        tick();
        busy_seen |= busy0;
        ddr_din = 64'd2; ddr_addr = 29'h3AB; ddr_burstcnt = 8'd9;
        tick();
        busy_seen |= busy0;
        ddr_we = 1'b0; ddr_din = 64'hDEAD;
        tick();
        busy_seen |= busy0;
        ddr_we = 1'b1; ddr_din = 64'd3;
        tick();
        busy_seen |= busy0;
        ddr_din = 64'd4;
        tick();
        ddr_we = 1'b0;
        vectors++;
        if (busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL wburst_busy: busy during write burst=%b expected 0", busy_seen);
        end
        do_read(0, 29'h100, 8'd4);
        vectors++;
        if (rd_n !== 4) begin
            errors++;
            $display("FAIL rburst_count: words=%0d expected 4", rd_n);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rd_words[k] !== 64'(k + 1) || rd_cyc[k] !== k + 2) begin
                errors++;
                $display("FAIL rburst_word%0d: data=%h cycle=%0d expected %h %0d",
                         k, rd_words[k], rd_cyc[k], 64'(k + 1), k + 2);
            end
        end
        vectors++;
        if (rd_busy[1] !== 1'b1 || rd_busy[5] !== 1'b1 || rd_busy[6] !== 1'b0) begin
            errors++;
            $display("FAIL rburst_busy: T+1=%b T+5=%b T+6=%b expected 1 1 0", rd_busy[1], rd_busy[5], rd_busy[6]);
        end
    endtask

    task automatic test_wrap();
        wr1(0, 29'h3FF, 64'h1111, 8'hFF);
        wr1(0, 29'h000, 64'h2222, 8'hFF);
        wr1(0, 29'h001, 64'h3333, 8'hFF);
        do_read(0, 29'h3FF, 8'd3);
        vectors++;
        if (rd_n !== 3 || rd_words[0] !== 64'h1111 || rd_words[1] !== 64'h2222 || rd_words[2] !== 64'h3333) begin
            errors++;
            $display("FAIL wrap: words=%0d data=%h %h %h expected 3 1111 2222 3333",
                     rd_n, rd_words[0], rd_words[1], rd_words[2]);
        end
        do_read(0, 29'h10, 8'd0);
        vectors++;
        if (rd_n !== 1 || rd_words[0] !== 64'h0123456789ABCDEF || rd_busy[3] !== 1'b0) begin
            errors++;
            $display("FAIL burstcnt_zero: words=%0d data=%h busyT+3=%b expected 1 0123456789abcdef 0",
                     rd_n, rd_words[0], rd_busy[3]);
        end
    endtask

    task automatic test_busy_insert();
        int  beat;
        logic exp_b;
        wr1(3, 29'h208, 64'h5E5E, 8'hFF);
        for (int w = 0; w < 20 && busy3; w++) tick();
        ddr_we = 1'b1; ddr_rd = 1'b1; ddr_addr = 29'h200; ddr_burstcnt = 8'd8;
        ddr_be = 8'hFF; ddr_din = 64'hA0;
        beat = 0;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            exp_b = (mcnt == 2);
            vectors++;
            if (busy3 !== exp_b) begin
                errors++;
                $display("FAIL busy_insert_c%0d: busy=%b expected %b", c, busy3, exp_b);
            end
            if (!busy3) beat++;
            tick();
            ddr_din  = 64'hA0 + 64'(beat);
            ddr_addr = 29'h0;
        end
        ddr_we = 1'b0; ddr_rd = 1'b0;
        vectors++;
        if (beat !== 8) begin
            errors++;
            $display("FAIL busy_insert_beats: accepted=%0d expected 8", beat);
        end
        do_read(3, 29'h200, 8'd9);
        vectors++;
        if (rd_n !== 9 || rd_wait > 2) begin
            errors++;
            $display("FAIL busy_readback_count: words=%0d wait=%0d expected 9 <=2", rd_n, rd_wait);
        end
        for (int k = 0; k < 9; k++) begin
            vectors++;
            if (rd_words[k] !== ((k < 8) ? 64'hA0 + 64'(k) : 64'h5E5E) || rd_cyc[k] !== k + 2) begin
                errors++;
                $display("FAIL busy_readback_w%0d: data=%h cycle=%0d expected %h %0d", k, rd_words[k],
                         rd_cyc[k], (k < 8) ? 64'hA0 + 64'(k) : 64'h5E5E, k + 2);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        ddr_addr = 29'h100; ddr_burstcnt = 8'd16; ddr_rd = 1'b1;
        tick();
        ddr_rd = 1'b0;
        tick();
        vectors++;
        if (ready0 !== 1'b1 || dout0 !== 64'd1) begin
            errors++;
            $display("FAIL midburst_running: ready=%b dout=%h expected 1 1", ready0, dout0);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ready0 !== 1'b0 || busy0 !== 1'b0 || dout0 !== 64'd0) begin
            errors++;
            $display("FAIL midburst_reset: ready=%b busy=%b dout=%h expected 0 0 0", ready0, busy0, dout0);
        end
        tick(); tick();
        rst_n = 1'b1;
        do_read(0, 29'h100, 8'd1);
        vectors++;
        if (rd_wait !== 0 || rd_n !== 1 || rd_words[0] !== 64'd1) begin
            errors++;
            $display("FAIL after_reset_read: wait=%0d words=%0d data=%h expected 0 1 1", rd_wait, rd_n, rd_words[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_byte_enable();
        test_write_burst();
        test_wrap();
        test_busy_insert();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtframe_mr_ddrslave.md
Name: jtframe_mr_ddrslave

Overview:
- Avalon-MM burst responder for the MiSTer DDR port: answers the same burstcnt/addr/rd/we/be/busy requests the DDR initiators issue.
- Backed by an internal 64-bit-wide block RAM.
- Stands in for the HPS DDR in simulation and on boards without DDR, so the ROM-load and rotation paths can run unchanged.
- Optional periodic busy insertion exercises initiator wait-request handling.

Parameters:
- AW, 10: BRAM address width in 64-bit words; depth is 2**AW.
- BUSY_EVERY, 0: if nonzero, force busy for one cycle every BUSY_EVERY cycles. 0 disables.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ddr_burstcnt  input  8  burst length in words; 0 is treated as 1.
- ddr_addr  input  29  64-bit word address; only bits [AW-1:0] are used.
- ddr_rd  input  1  read request.
- ddr_we  input  1  write beat valid.
- ddr_be  input  8  byte enables for the write beat; bit i covers bits [8i+7:8i].
- ddr_din  input  64  write data.
- ddr_busy  output  1  wait-request.
- ddr_dout  output  64  read data.
- ddr_dout_ready  output  1  read data valid, one word per asserted cycle.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State IDLE; ddr_busy=0, ddr_dout_ready=0, ddr_dout=0.
  - Burst counter, address register and busy-insertion counter all cleared.
  - BRAM contents are not cleared.
  - Reset mid-burst abandons the burst; remaining read words are never returned.
- Request acceptance: a request is accepted only on a cycle where ddr_busy=0.
- Injected busy: when BUSY_EVERY!=0, a free-running counter asserts ddr_busy for one cycle each time it reaches BUSY_EVERY-1, then wraps to 0. This busy is ORed with the state busy.
- State IDLE:
  - ddr_we=1 and not busy: write word addr using ddr_be. If burstcnt>1, go to WRITE with remaining=burstcnt-1 and next address = addr+1.
  - ddr_rd=1, ddr_we=0 and not busy: latch addr and N=burstcnt (0 becomes 1), then go to READ.
  - rd and we asserted together: the write wins and rd is ignored.
- State WRITE:
  - Each cycle with ddr_we=1 and not busy writes ddr_din under ddr_be to the address register, increments the address and decrements remaining.
  - Address and burstcnt are ignored during the burst.
  - After the last beat (remaining reaches 0), return to IDLE.
  - Cycles with ddr_we=0 hold state.
  - ddr_rd is ignored.
  - ddr_busy stays 0 except for injected busy.
- State READ (acceptance at cycle T):
  - ddr_busy=1 from T+1 through the cycle of the last data word.
  - BRAM read latency is 1: words addr..addr+N-1 appear on ddr_dout with ddr_dout_ready=1 at cycles T+2 .. T+1+N, with no gaps.
  - Injected busy does not stall read data.
  - Return to IDLE after the last word; ddr_busy drops at T+2+N unless an injected busy is active.
- Addressing: word addresses wrap modulo 2**AW within a burst (e.g. AW=10, start 0x3FF, N=2 reads 0x3FF then 0x000).
- ddr_dout holds its last value when ddr_dout_ready=0.
- A BRAM write and a read of the same word in the same cycle returns the old data. This cannot occur across states but is defined anyway.

Test Plan:
- Single write then read, AW=10, BUSY_EVERY=0:
  - Stimulus: write addr 0x10, be=0xFF, din=0x0123456789ABCDEF, burstcnt=1; then read addr 0x10, burstcnt=1 accepted at T.
  - Required: dout_ready=1 only at T+2 with dout=0x0123456789ABCDEF; busy high at T+1 and T+2, low at T+3.
- Byte enables:
  - Stimulus: write 0xFFFFFFFFFFFFFFFF to 0x20, then be=0x0F with din=0; read back.
  - Required: 0xFFFFFFFF00000000.
- Write burst of 4 then read burst of 4:
  - Stimulus: write 0x100.. with data k+1 and one we=0 gap mid-burst; then read burst 0x100, N=4 accepted at T.
  - Required: gap is held without corrupting the burst; read returns 1,2,3,4 at T+2..T+5 contiguously; busy deasserts at T+6.
- Wrap and burstcnt=0:
  - Stimulus: read burst at 0x3FF, N=3; separately, read with burstcnt=0.
  - Required: burst reads 0x3FF, 0x000, 0x001. burstcnt=0 read returns exactly one word.
- BUSY_EVERY=3:
  - Stimulus: hold ddr_we=1 for an 8-beat write burst.
  - Required: only cycles with busy=0 are accepted; exactly 8 words written, at consecutive addresses; rd asserted together with we is ignored.
- Reset mid-burst:
  - Stimulus: rst_n low two cycles into a 16-word read.
  - Required: dout_ready=0 and busy=0 immediately; after release, a new read is accepted on the first cycle.
